// File: rtl/wb_regfile_if.sv
// Write-back bundle from MEM/WB plus the decode/execute read side of the
// register file. The master drives commits and read requests; the slave
// (the register file) returns read data, bypassed HI/LO and the commit count.
interface wb_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              wb_wreg;
  logic [ADDR_W-1:0] wb_wd;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [CNT_W-1:0]  commit_cnt;

  modport master (
    output wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    output re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, commit_cnt
  );

  modport slave (
    input  wb_wreg, wb_wd, wb_wdata, wb_whilo, wb_hi, wb_lo,
    input  re1, raddr1, re2, raddr2,
    output rdata1, rdata2, hi_o, lo_o, commit_cnt
  );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage register file: 32 GPRs (entry 0 hardwired to zero),
// HI/LO pair and a committed-write counter. Reads are combinational with a
// bypass of the write that commits on the coming edge. rst is active-low
// and asynchronous; while it is low every output is forced to zero.
module wb_regfile #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int REG_NUM = 32,
  parameter int CNT_W   = 32
) (
  input logic          clk,
  input logic          rst,
  wb_regfile_if.slave  bus
);

  logic [DATA_W-1:0] gpr_reg [REG_NUM];
  logic [DATA_W-1:0] hi_reg;
  logic [DATA_W-1:0] lo_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  cnt_next;

  logic              gpr_wr_en;
  logic              commit;

  logic              re_vec    [2];
  logic [ADDR_W-1:0] raddr_vec [2];

  // Writes to $0 are dropped, so entry 0 never leaves its reset value.
  assign gpr_wr_en = bus.wb_wreg && (bus.wb_wd != '0);
  // A cycle counts once whether it commits a GPR, HI/LO or both.
  assign commit    = gpr_wr_en || bus.wb_whilo;
  assign cnt_next  = commit ? cnt_reg + CNT_W'(1) : cnt_reg;

  assign re_vec[0]    = bus.re1;
  assign re_vec[1]    = bus.re2;
  assign raddr_vec[0] = bus.raddr1;
  assign raddr_vec[1] = bus.raddr2;

  // GPR storage: cleared on reset, one write port from MEM/WB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        gpr_reg[i] <= '0;
      end
    end else if (gpr_wr_en) begin
      gpr_reg[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  // HI and LO always commit together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (bus.wb_whilo) begin
      hi_reg <= bus.wb_hi;
      lo_reg <= bus.wb_lo;
    end
  end

  // Committed-cycle counter, wraps silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  // Two identical read ports: reset, disabled and $0 read zero; otherwise the
  // committing write wins over storage.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_rd
      logic [DATA_W-1:0] rdata;
      // Read mux with same-cycle write bypass.
      always_comb begin
        rdata = '0;
        if (rst && re_vec[gi] && (raddr_vec[gi] != '0)) begin
          if (bus.wb_wreg && (bus.wb_wd == raddr_vec[gi])) begin
            rdata = bus.wb_wdata;
          end else begin
            rdata = gpr_reg[raddr_vec[gi]];
          end
        end
      end
    end
  endgenerate

  assign bus.rdata1 = gen_rd[0].rdata;
  assign bus.rdata2 = gen_rd[1].rdata;

  // HI/LO outputs with bypass of the committing HI/LO write.
  always_comb begin
    bus.hi_o = '0;
    bus.lo_o = '0;
    if (rst) begin
      bus.hi_o = bus.wb_whilo ? bus.wb_hi : hi_reg;
      bus.lo_o = bus.wb_whilo ? bus.wb_lo : lo_reg;
    end
  end

  assign bus.commit_cnt = rst ? cnt_reg : '0;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
Write-back end of the MEM/WB pipeline register: consumes the wb_* bundle (GPR write and HI/LO write) and commits it into the 32-entry general register file and the HI/LO pair. Serves two combinational GPR read ports for the decode stage and HI/LO read for execute, with same-cycle write-to-read bypass. Keeps a committed-write counter for debug and performance monitoring.

Parameters:
DATA_W, 32, width of GPR, HI and LO data
ADDR_W, 5, GPR address width
REG_NUM, 32, number of GPRs; entry 0 is hardwired to zero
CNT_W, 32, width of commit counter

Ports:
clk  in  1  system clock, rising edge active
rst  in  1  asynchronous, active-low reset
wb_wreg  in  1  GPR write enable from MEM/WB
wb_wd  in  ADDR_W  GPR write address
wb_wdata  in  DATA_W  GPR write data
wb_whilo  in  1  HI/LO write enable from MEM/WB
wb_hi  in  DATA_W  HI write data
wb_lo  in  DATA_W  LO write data
re1  in  1  read port 1 enable
raddr1  in  ADDR_W  read port 1 address
rdata1  out  DATA_W  read port 1 data
re2  in  1  read port 2 enable
raddr2  in  ADDR_W  read port 2 address
rdata2  out  DATA_W  read port 2 data
hi_o  out  DATA_W  current HI value (bypassed)
lo_o  out  DATA_W  current LO value (bypassed)
commit_cnt  out  CNT_W  count of committing cycles

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk, rst). While rst=0: all GPRs, HI, LO and commit_cnt cleared to 0 immediately, independent of clk; rdata1, rdata2, hi_o, lo_o forced to 0. Reset asserted mid-write discards that write.
- GPR write: at rising clk edge, if wb_wreg=1 and wb_wd!=0, reg[wb_wd] <= wb_wdata. Writes to address 0 are dropped; reg[0] always reads 0.
- HI/LO write: at rising clk edge, if wb_whilo=1, HI <= wb_hi and LO <= wb_lo (both together, never one alone).
- Read port n (combinational, zero latency), priority order:
  1. rst=0 -> 0
  2. ren=0 -> 0
  3. raddrn=0 -> 0
  4. wb_wreg=1 and wb_wd=raddrn -> wb_wdata (bypass of the write committing this cycle)
  5. else reg[raddrn]
- Both ports may read the same address, and both may bypass in the same cycle.
- hi_o/lo_o: wb_whilo=1 -> wb_hi/wb_lo (bypass); else HI/LO registers.
- Stalled or flushed MEM/WB presents wreg=0, whilo=0: no state change, no count.
- commit_cnt: at rising edge, +1 when (wb_wreg=1 and wb_wd!=0) or wb_whilo=1; exactly +1 even when both fire. Write to $0 alone does not count. Wraps from 2^CNT_W-1 to 0, no saturation or flag.
- No X propagation: unknown enables are not legal; no internal checks are required.

Test Plan:
- Reset: hold rst=0 with wb_wreg=1, wd=5, wdata=0x1234 across edges -> rdata1=0, hi_o=0, commit_cnt=0; release, read r5 -> 0.
- Write/read: write r7=0xDEADBEEF, next cycle re1=1, raddr1=7 -> rdata1=0xDEADBEEF; same read with re1=0 -> 0.
- Bypass: in the same cycle write r3=0x55 with re1=re2=1, raddr1=raddr2=3 -> both read 0x55 before the edge; after the edge both still read 0x55 from storage.
- $0 protection: wb_wreg=1, wd=0, wdata=0xFFFFFFFF -> raddr1=0 reads 0 in the same and next cycle; commit_cnt unchanged.
- HI/LO: whilo=1, hi=0xA, lo=0xB -> hi_o=0xA, lo_o=0xB in the same cycle and after; with wreg=1 (wd=2) in the same cycle -> commit_cnt +1 only.
- Counter wrap and async reset: preload by 2^32-1 commits (use CNT_W=4, 15 commits) -> next commit gives 0; assert rst=0 between edges -> all outputs 0 immediately.
